// File: rtl/mem_resp_ws.sv
// Single-port memory responder: one request at a time, WAIT_CYCLES wait states, write-protect window.
// Latency: request sampled at E0, ready/err pulse at E0+1+WAIT_CYCLES, idle again two edges later.
// Backpressure: requests are only sampled in IDLE; valid/addr/wdata/wr_rd are ignored while busy.
module mem_resp_ws #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int WAIT_CYCLES = 2,
    parameter int WP_LO       = 48,
    parameter int WP_HI       = 55
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);
    localparam logic [31:0] WP_LO_U  = WP_LO;
    localparam logic [31:0] WP_HI_U  = WP_HI;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wcnt;
    logic [3:0]            wcnt_nxt;
    logic                  capture;
    logic                  complete;
    logic                  protect;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WIDTH-1:0]      req_wdata;

    // An empty window (WP_LO > WP_HI) can never satisfy both bounds.
    assign protect = (32'(req_addr) >= WP_LO_U) && (32'(req_addr) <= WP_HI_U);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        capture   = 1'b0;
        complete  = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    capture   = 1'b1;
                    wcnt_nxt  = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt == WAIT_LIM) begin
                    complete  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    wcnt_nxt = wcnt + 4'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            ready <= complete;
            err   <= complete && req_wr && protect;
            if (capture) begin
                req_wr    <= wr_rd;
                req_addr  <= addr;
                req_wdata <= wdata;
            end
            if (complete && !req_wr) begin
                rdata <= mem[req_addr];
            end
        end
    end

    // Array is deliberately unreset; a reset forces IDLE so no completion can write.
    always_ff @(posedge clk) begin
        if (complete && req_wr && !protect) begin
            mem[req_addr] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_resp_ws.sv
// Bench for mem_resp_ws: instance 0 with 2 wait states, instance 1 with none.
// A timestamped request model predicts ready/err/rdata; a negedge process compares every cycle.
module tb_mem_resp_ws;
    localparam int WP_LO = 48;
    localparam int WP_HI = 55;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  v, wr, rdy, er;
    logic [5:0]  a  [2];
    logic [15:0] wd [2];
    logic [15:0] rd [2];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int wc [2] = '{2, 0};

    logic [15:0] mm [2][64];
    bit          mk [2][64];
    bit          pv [2];
    bit          pw [2];
    int          pc [2];
    logic [5:0]  pa [2];
    logic [15:0] pd [2];
    logic [15:0] erd [2];
    bit          erk [2];
    int          pulses [2] = '{0, 0};
    bit          exp_rdy, exp_err;

    int   c, e0, prev_c, p0;
    logic e;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    mem_resp_ws #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .valid(v[0]), .wr_rd(wr[0]), .addr(a[0]),
        .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]), .err(er[0])
    );

    mem_resp_ws #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .valid(v[1]), .wr_rd(wr[1]), .addr(a[1]),
        .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]), .err(er[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Each request completes exactly 1+wait edges after the edge that samples it.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_rdy = 1'b0;
            exp_err = 1'b0;
            if (pv[k] && edge_cnt == pc[k]) begin
                exp_rdy = 1'b1;
                pv[k]   = 1'b0;
                if (pw[k]) begin
                    if (int'(pa[k]) >= WP_LO && int'(pa[k]) <= WP_HI) begin
                        exp_err = 1'b1;
                    end else begin
                        mm[k][pa[k]] = pd[k];
                        mk[k][pa[k]] = 1'b1;
                    end
                end else begin
                    erd[k] = mm[k][pa[k]];
                    erk[k] = mk[k][pa[k]];
                end
            end
            if (rdy[k]) pulses[k]++;
            chk($sformatf("ready%0d@%0d", k, edge_cnt), 32'(rdy[k]), 32'(exp_rdy));
            chk($sformatf("err%0d@%0d", k, edge_cnt), 32'(er[k]), 32'(exp_err));
            if (erk[k]) chk($sformatf("rdata%0d@%0d", k, edge_cnt), 32'(rd[k]), 32'(erd[k]));
        end
    end

    // Called just after a rising edge; returns just after the DONE edge.
    task automatic req(input int k, input bit w, input logic [5:0] ad, input logic [15:0] d,
                       output int cy, output int ecap, output logic eo);
        v[k] = 1'b1; wr[k] = w; a[k] = ad; wd[k] = d;
        @(posedge clk); #1;
        ecap  = edge_cnt;
        pw[k] = w; pa[k] = ad; pd[k] = d;
        pc[k] = edge_cnt + 1 + wc[k];
        pv[k] = 1'b1;
        v[k] = 1'b0; a[k] = ad + 6'd1; wd[k] = ~d;
        cy = -1;
        eo = 1'b0;
        for (int i = 0; i < 40 && cy < 0; i++) begin
            @(negedge clk);
            if (rdy[k]) begin
                cy = edge_cnt;
                eo = er[k];
            end
        end
        if (cy < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout inst %0d: got no ready, required one", k);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        v = '0; wr = '0; a = '{6'd0, 6'd0}; wd = '{16'd0, 16'd0};
        erd = '{16'd0, 16'd0}; erk = '{1'b1, 1'b1}; pv = '{1'b0, 1'b0};
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 32'(rdy[k]), 32'd0);
            chk("reset_err", 32'(er[k]), 32'd0);
            chk("reset_rdata", 32'(rd[k]), 32'd0);
        end
        @(posedge clk); #1;

        req(0, 1'b1, 6'd5, 16'h1234, c, e0, e);
        chk("t1_latency", 32'(c - e0), 32'd3);
        chk("t1_err", 32'(e), 32'd0);
        req(0, 1'b0, 6'd5, 16'h0, c, e0, e);
        chk("t1_rdata", 32'(rd[0]), 32'h1234);

        p0 = pulses[0];
        for (int i = 0; i < 64; i++) req(0, 1'b1, 6'(i), 16'($urandom), c, e0, e);
        for (int i = 0; i < 64; i++) req(0, 1'b0, 6'(i), 16'h0, c, e0, e);
        chk("sweep_pulses", 32'(pulses[0] - p0), 32'd128);

        req(0, 1'b1, 6'd48, 16'hAAAA, c, e0, e);
        chk("wp48_err", 32'(e), 32'd1);
        req(0, 1'b1, 6'd50, 16'h5555, c, e0, e);
        chk("wp50_err", 32'(e), 32'd1);
        req(0, 1'b0, 6'd48, 16'h0, c, e0, e);
        req(0, 1'b0, 6'd50, 16'h0, c, e0, e);
        req(0, 1'b1, 6'd47, 16'h4747, c, e0, e);
        chk("wp47_err", 32'(e), 32'd0);
        req(0, 1'b0, 6'd47, 16'h0, c, e0, e);
        chk("wp47_rdata", 32'(rd[0]), 32'h4747);

        for (int i = 10; i < 16; i++) req(1, 1'b1, 6'(i), 16'h0A00 + 16'(i), c, e0, e);
        p0 = pulses[1];
        prev_c = 0;
        for (int i = 10; i < 16; i++) begin
            req(1, 1'b0, 6'(i), 16'h0, c, e0, e);
            chk($sformatf("w0_rdata%0d", i), 32'(rd[1]), 32'h0A00 + 32'(i));
            if (i > 10) chk($sformatf("w0_spacing%0d", i), 32'(c - prev_c), 32'd3);
            prev_c = c;
        end
        chk("w0_pulses", 32'(pulses[1] - p0), 32'd6);

        req(0, 1'b1, 6'd21, 16'h2121, c, e0, e);
        req(0, 1'b1, 6'd20, 16'hBEEF, c, e0, e);
        req(0, 1'b0, 6'd20, 16'h0, c, e0, e);
        chk("pulse_addr20", 32'(rd[0]), 32'hBEEF);
        req(0, 1'b0, 6'd21, 16'h0, c, e0, e);
        chk("pulse_addr21", 32'(rd[0]), 32'h2121);

        req(0, 1'b1, 6'd7, 16'h7777, c, e0, e);
        req(0, 1'b0, 6'd7, 16'h0, c, e0, e);
        chk("pre_rst_rdata", 32'(rd[0]), 32'h7777);
        v[0] = 1'b1; wr[0] = 1'b1; a[0] = 6'd7; wd[0] = 16'h0F0F;
        @(posedge clk); #1;
        pw[0] = 1'b1; pa[0] = 6'd7; pd[0] = 16'h0F0F; pc[0] = edge_cnt + 3; pv[0] = 1'b1;
        v[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        pv = '{1'b0, 1'b0}; erd = '{16'd0, 16'd0}; erk = '{1'b1, 1'b1};
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_err", 32'(er[0]), 32'd0);
        chk("rst_rdata", 32'(rd[0]), 32'd0);
        chk("rst_rdata_w0", 32'(rd[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        p0 = pulses[0];
        repeat (8) @(posedge clk);
        #1;
        chk("rst_no_ready", 32'(pulses[0] - p0), 32'd0);
        req(0, 1'b0, 6'd7, 16'h0, c, e0, e);
        chk("rst_addr7_kept", 32'(rd[0]), 32'h7777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
